// File: rtl/display_pkg.sv
// Shared types and helpers for the 4-digit display scan controller.
package display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEL_W      = 2;
    localparam int NIB_W      = 4;
    localparam int DATA_W     = NUM_DIGITS * NIB_W;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP
    } state_t;

    function automatic logic [NIB_W-1:0] nibble_of(
        input logic [DATA_W-1:0] value,
        input logic [SEL_W-1:0]  sel
    );
        logic [NIB_W-1:0] nib;
        case (sel)
            2'd0:    nib = value[3:0];
            2'd1:    nib = value[7:4];
            2'd2:    nib = value[11:8];
            default: nib = value[15:12];
        endcase
        return nib;
    endfunction

    // A digit is a leading zero when it and every more-significant digit are zero.
    function automatic logic is_leading_zero(
        input logic [DATA_W-1:0] value,
        input logic [SEL_W-1:0]  sel
    );
        logic lz;
        case (sel)
            2'd3:    lz = (value[15:12] == '0);
            2'd2:    lz = (value[15:8] == '0);
            2'd1:    lz = (value[15:4] == '0);
            default: lz = 1'b0;
        endcase
        return lz;
    endfunction

endpackage

// File: rtl/slot_timer.sv
// Loadable down-counter with a terminal flag; times both the SHOW and GAP slots.
module slot_timer #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    output logic          done,
    output logic          one_left
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign done     = (count == '0);
    assign one_left = (count == CW'(1));

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed 4-digit scan controller with double-buffered value load
// and optional leading-zero blanking. All outputs come straight from flops.
module digit_scan_ctrl
    import display_pkg::*;
#(
    parameter int DIV   = 4,
    parameter int BLANK = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        blank_lz,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    output logic [1:0]  sel,
    output logic        sel_en,
    output logic [3:0]  nibble,
    output logic        frame_done
);

    localparam int MAXC = (DIV > BLANK) ? DIV : BLANK;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] SHOW_LOAD = CW'(DIV - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'((BLANK > 0) ? (BLANK - 1) : 0);

    state_t            state, state_nxt;
    logic [SEL_W-1:0]  sel_nxt;
    logic [DATA_W-1:0] active, active_nxt, pending;
    logic              pending_full;
    logic              commit;
    logic              t_load, t_clear, t_done, t_one;
    logic [CW-1:0]     t_value;
    logic              next_zero;
    logic              sel_en_nxt, frame_done_nxt;
    logic [NIB_W-1:0]  nibble_nxt;

    assign pending_full = !load_ready;

    slot_timer #(.CW(CW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .clear      (t_clear),
        .load       (t_load),
        .load_value (t_value),
        .done       (t_done),
        .one_left   (t_one)
    );

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        t_load    = 1'b0;
        t_clear   = 1'b0;
        t_value   = SHOW_LOAD;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                sel_nxt = '0;
                if (enable) begin
                    state_nxt = SHOW;
                    t_load    = 1'b1;
                    commit    = 1'b1;
                end else begin
                    t_clear = 1'b1;
                end
            end
            SHOW: begin
                if (!enable) begin
                    state_nxt = IDLE;
                    sel_nxt   = '0;
                    t_clear   = 1'b1;
                end else if (t_done) begin
                    t_load = 1'b1;
                    if (BLANK > 0) begin
                        state_nxt = GAP;
                        t_value   = GAP_LOAD;
                    end else begin
                        sel_nxt = sel + SEL_W'(1);
                        commit  = (sel == '1);
                    end
                end
            end
            GAP: begin
                if (!enable) begin
                    state_nxt = IDLE;
                    sel_nxt   = '0;
                    t_clear   = 1'b1;
                end else if (t_done) begin
                    state_nxt = SHOW;
                    sel_nxt   = sel + SEL_W'(1);
                    t_load    = 1'b1;
                    commit    = (sel == '1);
                end
            end
            default: begin
                state_nxt = IDLE;
                sel_nxt   = '0;
                t_clear   = 1'b1;
            end
        endcase
    end

    // Outputs are precomputed from next-cycle state so they can be registered.
    always_comb begin
        active_nxt     = (commit && pending_full) ? pending : active;
        next_zero      = t_clear || (t_load ? (t_value == '0) : t_one);
        frame_done_nxt = ((state_nxt == GAP) || ((BLANK == 0) && (state_nxt == SHOW)))
                         && (sel_nxt == '1) && next_zero;
        sel_en_nxt     = (state_nxt == SHOW)
                         && !(blank_lz && is_leading_zero(active_nxt, sel_nxt));
        nibble_nxt     = nibble_of(active_nxt, sel_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= '0;
            sel_en     <= 1'b0;
            nibble     <= '0;
            frame_done <= 1'b0;
            active     <= '0;
            pending    <= '0;
            load_ready <= 1'b1;
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            sel_en     <= sel_en_nxt;
            nibble     <= nibble_nxt;
            frame_done <= frame_done_nxt;
            active     <= active_nxt;
            // A load landing on a commit cycle stays pending until the next frame.
            if (load_valid && load_ready) begin
                pending    <= load_data;
                load_ready <= 1'b0;
            end else if (commit && pending_full) begin
                load_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl: directed stimulus queues expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_digit_scan_ctrl;

    typedef struct packed {
        logic [1:0] sel;
        logic       en;
        logic [3:0] nib;
        logic       fd;
        logic       rdy;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, blank_lz, load_valid;
    logic [15:0] load_data;
    logic        load_ready, sel_en, frame_done;
    logic [1:0]  sel;
    logic [3:0]  nibble;

    logic        f_enable, f_blank_lz, f_load_valid;
    logic [15:0] f_load_data;
    logic        f_load_ready, f_sel_en, f_frame_done;
    logic [1:0]  f_sel;
    logic [3:0]  f_nibble;

    obs_t q_main[$];
    int   t_main[$];
    obs_t q_fast[$];
    int   t_fast[$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    digit_scan_ctrl #(.DIV(4), .BLANK(1)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .blank_lz   (blank_lz),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .sel        (sel),
        .sel_en     (sel_en),
        .nibble     (nibble),
        .frame_done (frame_done)
    );

    digit_scan_ctrl #(.DIV(1), .BLANK(0)) u_fast (
        .clk        (clk),
        .rst        (rst),
        .enable     (f_enable),
        .blank_lz   (f_blank_lz),
        .load_valid (f_load_valid),
        .load_ready (f_load_ready),
        .load_data  (f_load_data),
        .sel        (f_sel),
        .sel_en     (f_sel_en),
        .nibble     (f_nibble),
        .frame_done (f_frame_done)
    );

    always @(negedge clk) begin
        obs_t exp_o, got_o;
        int   tag;
        if (q_main.size() > 0) begin
            exp_o = q_main.pop_front();
            tag   = t_main.pop_front();
            got_o = '{sel, sel_en, nibble, frame_done, load_ready};
            checks++;
            if (got_o !== exp_o) begin
                failures++;
                $display("FAIL scan_t%0d @%0t got sel=%0d en=%b nib=%h fd=%b rdy=%b want sel=%0d en=%b nib=%h fd=%b rdy=%b",
                         tag, $time, got_o.sel, got_o.en, got_o.nib, got_o.fd, got_o.rdy,
                         exp_o.sel, exp_o.en, exp_o.nib, exp_o.fd, exp_o.rdy);
            end
        end
        if (q_fast.size() > 0) begin
            exp_o = q_fast.pop_front();
            tag   = t_fast.pop_front();
            got_o = '{f_sel, f_sel_en, f_nibble, f_frame_done, f_load_ready};
            checks++;
            if (got_o !== exp_o) begin
                failures++;
                $display("FAIL fast_t%0d @%0t got sel=%0d en=%b nib=%h fd=%b rdy=%b want sel=%0d en=%b nib=%h fd=%b rdy=%b",
                         tag, $time, got_o.sel, got_o.en, got_o.nib, got_o.fd, got_o.rdy,
                         exp_o.sel, exp_o.en, exp_o.nib, exp_o.fd, exp_o.rdy);
            end
        end
    end

    // Queue the expected outputs of the current cycle, then advance one clock.
    task automatic cyc(input logic [1:0] s, input logic e, input logic [3:0] n,
                       input logic f, input logic r, input int tag);
        obs_t o;
        o = '{s, e, n, f, r};
        q_main.push_back(o);
        t_main.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic fcyc(input logic [1:0] s, input logic e, input logic [3:0] n,
                        input logic f, input logic r, input int tag);
        obs_t o;
        o = '{s, e, n, f, r};
        q_fast.push_back(o);
        t_fast.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    // One DIV=4/BLANK=1 frame: per digit 4 SHOW cycles then 1 GAP cycle.
    task automatic frame(input logic [3:0] n0, input logic [3:0] n1,
                         input logic [3:0] n2, input logic [3:0] n3,
                         input logic [3:0] lit, input logic rdy0,
                         input int ld_at, input logic [15:0] ld_val,
                         input int ld2_at, input logic [15:0] ld2_val,
                         input int ncyc, input int tag);
        logic [3:0] nib [4];
        logic       rdy;
        nib = '{n0, n1, n2, n3};
        rdy = rdy0;
        for (int k = 0; k < ncyc; k++) begin
            int   d;
            logic gap;
            d   = k / 5;
            gap = (k % 5 == 4);
            load_valid = (k == ld_at) || (k == ld2_at);
            load_data  = (k == ld_at) ? ld_val : ld2_val;
            cyc(d[1:0], !gap && lit[d], nib[d], gap && (d == 3), rdy, tag);
            if (k == ld_at) rdy = 1'b0;
            load_valid = 1'b0;
        end
    endtask

    initial begin
        rst          = 1'b1;
        enable       = 1'b0;
        blank_lz     = 1'b0;
        load_valid   = 1'b0;
        load_data    = '0;
        f_enable     = 1'b0;
        f_blank_lz   = 1'b0;
        f_load_valid = 1'b0;
        f_load_data  = '0;

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        cyc(0, 0, 4'h0, 0, 1, 1);
        rst = 1'b0;
        cyc(0, 0, 4'h0, 0, 1, 1);

        // Basic scan of 4321.
        load_valid = 1'b1;
        load_data  = 16'h4321;
        cyc(0, 0, 4'h0, 0, 1, 2);
        load_valid = 1'b0;
        cyc(0, 0, 4'h0, 0, 0, 2);
        enable = 1'b1;
        cyc(0, 0, 4'h0, 0, 0, 2);
        frame(4'h1, 4'h2, 4'h3, 4'h4, 4'b1111, 1, -1, 16'h0, -1, 16'h0, 20, 3);

        // Double buffering: ABCD mid-frame, second load while stalled is dropped.
        frame(4'h1, 4'h2, 4'h3, 4'h4, 4'b1111, 1, 7, 16'hABCD, 12, 16'hFFFF, 20, 4);
        frame(4'hD, 4'hC, 4'hB, 4'hA, 4'b1111, 1, 0, 16'h0050, -1, 16'h0, 20, 5);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        frame(4'h0, 4'h5, 4'h0, 4'h0, 4'b0011, 1, 0, 16'h0000, -1, 16'h0, 20, 6);
        frame(4'h0, 4'h0, 4'h0, 4'h0, 4'b0001, 1, 0, 16'h9876, -1, 16'h0, 20, 7);

        // Enable drop during digit 2, then restart with the retained value.
        frame(4'h6, 4'h7, 4'h8, 4'h9, 4'b1111, 1, -1, 16'h0, -1, 16'h0, 11, 8);
        enable = 1'b0;
        cyc(2, 1, 4'h8, 0, 1, 8);
        cyc(0, 0, 4'h6, 0, 1, 8);
        cyc(0, 0, 4'h6, 0, 1, 8);
        enable = 1'b1;
        cyc(0, 0, 4'h6, 0, 1, 8);
        frame(4'h6, 4'h7, 4'h8, 4'h9, 4'b1111, 1, -1, 16'h0, -1, 16'h0, 20, 9);

        // Reset with a pending value discards it.
        enable     = 1'b0;
        load_valid = 1'b1;
        load_data  = 16'h1111;
        cyc(0, 1, 4'h6, 0, 1, 10);
        load_valid = 1'b0;
        cyc(0, 0, 4'h6, 0, 0, 10);
        rst = 1'b1;
        cyc(0, 0, 4'h6, 0, 0, 10);
        rst = 1'b0;
        cyc(0, 0, 4'h0, 0, 1, 10);
        enable = 1'b1;
        cyc(0, 0, 4'h0, 0, 1, 10);
        frame(4'h0, 4'h0, 4'h0, 4'h0, 4'b0001, 1, -1, 16'h0, -1, 16'h0, 20, 11);
        enable = 1'b0;
        cyc(0, 1, 4'h0, 0, 1, 11);

        // DIV=1, BLANK=0 corner on the second instance.
        f_load_valid = 1'b1;
        f_load_data  = 16'h8A5F;
        fcyc(0, 0, 4'h0, 0, 1, 12);
        f_load_valid = 1'b0;
        f_enable     = 1'b1;
        fcyc(0, 0, 4'h0, 0, 0, 12);
        for (int i = 0; i < 3; i++) begin
            fcyc(0, 1, 4'hF, 0, 1, 13);
            fcyc(1, 1, 4'h5, 0, 1, 13);
            fcyc(2, 1, 4'hA, 0, 1, 13);
            fcyc(3, 1, 4'h8, 1, 1, 13);
        end
        f_enable = 1'b0;

        for (int w = 0; w < 4 && (q_main.size() > 0 || q_fast.size() > 0); w++) begin
            @(posedge clk);
        end
        if (q_main.size() > 0 || q_fast.size() > 0) begin
            failures++;
            $display("FAIL drain got main=%0d fast=%0d pending entries want 0",
                     q_main.size(), q_fast.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
Time-multiplexed scan controller for a 4-digit display. Holds a 16-bit value (four BCD/hex nibbles) and steps a 2-bit digit index through 0..3. The index `sel` feeds the downstream 2-to-4 decoder, which produces the one-hot digit enables; `sel_en` gates that decoder. A double-buffered load path accepts new values at any time and commits them only at frame boundaries, so a frame never shows a torn value.

Parameters:
- DIV, 4: cycles each digit slot is shown (`sel_en` high); legal range >= 1.
- BLANK, 1: dead cycles after each slot with `sel_en` low (anti-ghosting); legal range >= 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run scanning; when low, the block parks in IDLE.
- blank_lz  in  1  leading-zero blanking enable.
- load_valid  in  1  load request.
- load_ready  out  1  pending buffer empty; a load is accepted when load_valid && load_ready.
- load_data  in  16  value to display; [3:0] = digit 0 (LSD), [15:12] = digit 3 (MSD).
- sel  out  2  digit index to the 2-to-4 decoder.
- sel_en  out  1  decoder enable; high = digit lit.
- nibble  out  4  active[sel*4 +: 4].
- frame_done  out  1  one-cycle pulse at the end of the digit-3 slot.

Behaviour:
- Reset values:
  - state = IDLE
  - sel = 0, sel_en = 0, nibble = 0, frame_done = 0
  - load_ready = 1
  - active = 0, pending = 0, pending_full = 0
  - slot counter = 0
- All outputs are registered.
- Load handshake:
  - load_ready = !pending_full.
  - On accept: pending <= load_data and pending_full <= 1.
  - While pending_full, further loads stall.
- Commit:
  - Occurs on every entry to the SHOW state for sel = 0, whether from IDLE or wrapping from digit 3.
  - If pending_full: active <= pending and pending_full <= 0.
  - A load accepted in the same cycle as a commit is not committed in that cycle; it waits for the next frame boundary.
- FSM states: IDLE, SHOW, GAP.
  - IDLE: sel = 0, sel_en = 0. If enable is sampled high, go to SHOW with sel = 0 (commit). First sel_en = 1 appears one cycle after enable is sampled.
  - SHOW: stays DIV cycles.
    - If BLANK > 0, go to GAP.
    - Else advance sel directly, staying in SHOW.
  - GAP: sel_en = 0, sel held, stays BLANK cycles. Then sel <= sel + 1 with wrap 3 -> 0, and back to SHOW.
- sel_en in SHOW is 1, except for a blanked leading digit (see below).
- Frame length is 4*(DIV+BLANK) cycles.
- frame_done is high for exactly one cycle: the last cycle of digit 3's slot (last GAP cycle, or last SHOW cycle if BLANK = 0).
- Leading-zero blanking:
  - If blank_lz = 1, digit i (i = 3, 2, 1) is blanked when active[15 : i*4] == 0.
  - Blanked means sel_en = 0 during its SHOW cycles; timing and sel stepping are unchanged.
  - Digit 0 is never blanked.
  - blank_lz is sampled every cycle.
- enable deasserted mid-frame:
  - Next cycle state = IDLE, sel = 0, sel_en = 0, slot counter cleared.
  - No frame_done pulse.
  - pending and active are retained.
- rst mid-operation returns all state to reset values, discarding pending.
- Counter widths: slot counter is $clog2(max(DIV, BLANK)+1) bits. The sel wrap is natural 2-bit overflow.

Decomposition:
- Shared package `display_pkg`:
  - state enum (IDLE/SHOW/GAP)
  - NUM_DIGITS = 4
  - SEL_W = 2, NIB_W = 4
- Sub-module `slot_timer`: a loadable down-counter with a done flag. It is reused for both the SHOW and GAP durations.

Test Plan:
All scenarios use DIV = 4, BLANK = 1.
1. Reset check: hold rst 3 cycles -> sel = 0, sel_en = 0, nibble = 0, frame_done = 0, load_ready = 1.
2. Basic scan:
   - Stimulus: load 16'h4321, raise enable.
   - Expected: sel sequence 0,0,0,0,0,1,... with sel_en pattern 1111_0 per digit; nibble = 1,2,3,4 in turn.
   - frame_done pulses on cycle 20 after the first SHOW; period stays 20 cycles.
3. Double buffering:
   - Stimulus: load 16'hABCD mid-frame while showing 16'h4321.
   - Expected: load_ready drops to 0; the current frame still shows 1,2,3,4; the next frame shows D,C,B,A; load_ready returns to 1 at the commit.
   - A second load_valid while load_ready = 0 is ignored.
4. Leading-zero blanking:
   - Stimulus: active = 16'h0050, blank_lz = 1.
   - Expected: sel_en low during digit 3 and digit 2 SHOW slots, high for digits 1 and 0.
   - With 16'h0000, only digit 0 is lit.
5. Enable drop and rst:
   - Drop enable during digit 2 -> next cycle sel = 0, sel_en = 0, no frame_done; re-enable -> restarts at digit 0 with the retained value.
   - Assert rst with pending_full = 1 -> pending is discarded and load_ready = 1.
6. Parameter corners:
   - DIV = 1, BLANK = 0 -> sel increments every cycle, sel_en is constant 1 (no blanking), frame_done every 4 cycles on sel = 3.
